multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control unit for the multicycle core. A Moore FSM steps each instruction through
//  fetch, decode, execute, memory and writeback. It drives the shared-ALU datapath:
//  ALU operation, mux selects and write enables.
//  Memory accesses use a ready handshake, so the FSM stalls on slow memory.
//  Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, slti, j.
// PARAMETERS
//  STATE_W  4  width of state register / dbg_state port
//  ALU_W    3  width of alucontrol
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  op          in   6       IR[31:26], stable from DECODE onward
//  funct       in   6       IR[5:0]
//  zero        in   1       ALU zero flag, valid in BEQ
//  mem_ready   in   1       memory completes the current access this cycle
//  mem_req     out  1       memory access request
//  iord        out  1       address mux: 0 = PC, 1 = ALUOut
//  memwrite    out  1       store strobe
//  irwrite     out  1       load IR
//  regdst      out  1       destination register: 0 = rt, 1 = rd
//  memtoreg    out  1       writeback data: 0 = ALUOut, 1 = MDR
//  regwrite    out  1       register file write
//  alusrca     out  1       ALU A input: 0 = PC, 1 = reg A
//  alusrcb     out  2       ALU B input: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//  pcsrc       out  2       next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
//  pcen        out  1       PC write enable (pcwrite | branch&zero)
//  alucontrol  out  ALU_W   000 and, 001 or, 010 add, 110 sub, 111 slt
//  instr_done  out  1       1-cycle pulse in the final state of each instruction
//  illegal_op  out  1       1-cycle pulse in DECODE when op is unsupported
//  dbg_state   out  STATE_W current state encoding
// BEHAVIOUR
//  State encodings: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6
//   ALUWB=7 BEQ=8 IMMEX=9 IMMWB=10 JUMP=11. Encodings 12-15 go to FETCH.
//  Reset: rst_n low forces state to FETCH asynchronously.
//   While rst_n is low, every output is 0 except dbg_state=0.
//  Outputs are combinational from state. They are additionally gated by mem_ready
//   in FETCH, MEMRD and MEMWR. Unlisted outputs are 0.
//  Transitions and outputs per state:
//   FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
//    irwrite and pcen only when mem_ready. Go to DECODE on mem_ready, else hold.
//   DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut).
//    Next state by op:
//     100011 (lw) / 101011 (sw) -> MEMADR
//     000000 -> EXEC
//     000100 -> BEQ
//     001000 / 001010 -> IMMEX
//     000010 -> JUMP
//     any other op -> FETCH with illegal_op=1
//   MEMADR: alusrca=1, alusrcb=10, alucontrol=010. lw -> MEMRD, sw -> MEMWR.
//   MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to MEMWB.
//   MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Then FETCH.
//   MEMWR: mem_req=1, iord=1, memwrite=mem_ready. Hold until mem_ready.
//    On mem_ready: instr_done=1, then FETCH.
//   EXEC: alusrca=1, alusrcb=00. alucontrol from funct:
//    100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111,
//    other funct -> 010.
//   ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1.
//   BEQ: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero, instr_done=1.
//   IMMEX: alusrca=1, alusrcb=10. alucontrol=010 for addi, 111 for slti.
//   IMMWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1.
//   JUMP: pcsrc=10, pcen=1, instr_done=1.
//   Every state not listed above goes to the next state on the path shown.
//    Final states (MEMWB, MEMWR, ALUWB, BEQ, IMMWB, JUMP) return to FETCH.
//  Cycle counts with mem_ready held high:
//   lw 5, sw 4, R-type 4, addi/slti 4, beq 3, j 3.
//   Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
//  At most one of regwrite/memwrite is high in any cycle.
//   irwrite is only ever high in FETCH.
//  Reset asserted mid-instruction abandons it: no further writes, restart at FETCH.
// TESTING
//  1. Reset: rst_n=0 for 3 cycles -> all outputs 0; after release dbg_state=0, mem_req=1.
//  2. lw (op=100011), mem_ready=1 -> states 0,1,2,3,4; regwrite+memtoreg in state 4;
//     instr_done once.
//  3. sw, mem_ready low for 3 cycles in MEMWR -> memwrite high exactly 1 cycle,
//     total 7 cycles.
//  4. R-type, funct sweep of 100000/100010/100100/100101/101010 -> alucontrol
//     010/110/000/001/111 in EXEC.
//  5. beq with zero=1 -> pcen=1, pcsrc=01 in BEQ; with zero=0 -> pcen=0 in BEQ.
//  6. op=111111 -> illegal_op pulse, FETCH next cycle. rst_n low during MEMRD ->
//     FETCH, no regwrite.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Datapath control bundle between the multicycle controller and its shared-ALU datapath.
// The controller side uses the master modport; the datapath/memory side uses the slave modport.
interface multicycle_controller_if #(
    parameter int ALU_W = 3
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             iord;
    logic             memwrite;
    logic             irwrite;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic             pcen;
    logic [ALU_W-1:0] alucontrol;
    logic             instr_done;
    logic             illegal_op;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, instr_done, illegal_op
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle core: fetch/decode/execute/memory/writeback with
// a ready handshake on memory states; outputs decode from state, gated by mem_ready where needed.
module multicycle_controller #(
    parameter int STATE_W = 4,
    parameter int ALU_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus,
    output logic [STATE_W-1:0]      dbg_state
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b000);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b001);
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b010);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b110);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b111);

    state_t state_r;

    // State register: advances along the instruction path, stalling on memory handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:  state_r <= bus.mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW:      state_r <= S_MEMADR;
                        OP_RTYPE:          state_r <= S_EXEC;
                        OP_BEQ:            state_r <= S_BEQ;
                        OP_ADDI, OP_SLTI:  state_r <= S_IMMEX;
                        OP_J:              state_r <= S_JUMP;
                        default:           state_r <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_r <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_r <= bus.mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:  state_r <= bus.mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:   state_r <= S_ALUWB;
                S_IMMEX:  state_r <= S_IMMWB;
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    assign dbg_state = STATE_W'(state_r);

    // Output decode; everything is held at zero while reset is asserted.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.pcen       = 1'b0;
        bus.alucontrol = ALU_AND;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        if (!rst_n) begin
            bus.mem_req = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    bus.mem_req    = 1'b1;
                    bus.alusrcb    = 2'b01;
                    bus.alucontrol = ALU_ADD;
                    bus.irwrite    = bus.mem_ready;
                    bus.pcen       = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alusrcb    = 2'b11;
                    bus.alucontrol = ALU_ADD;
                    case (bus.op)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
                        OP_ADDI, OP_SLTI, OP_J: bus.illegal_op = 1'b0;
                        default:                bus.illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    bus.alusrca    = 1'b1;
                    bus.alusrcb    = 2'b10;
                    bus.alucontrol = ALU_ADD;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEMWB: begin
                    bus.memtoreg   = 1'b1;
                    bus.regwrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_req    = 1'b1;
                    bus.iord       = 1'b1;
                    bus.memwrite   = bus.mem_ready;
                    bus.instr_done = bus.mem_ready;
                end
                S_EXEC: begin
                    bus.alusrca = 1'b1;
                    case (bus.funct)
                        6'b100010: bus.alucontrol = ALU_SUB;
                        6'b100100: bus.alucontrol = ALU_AND;
                        6'b100101: bus.alucontrol = ALU_OR;
                        6'b101010: bus.alucontrol = ALU_SLT;
                        default:   bus.alucontrol = ALU_ADD;
                    endcase
                end
                S_ALUWB: begin
                    bus.regdst     = 1'b1;
                    bus.regwrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BEQ: begin
                    bus.alusrca    = 1'b1;
                    bus.alucontrol = ALU_SUB;
                    bus.pcsrc      = 2'b01;
                    bus.pcen       = bus.zero;
                    bus.instr_done = 1'b1;
                end
                S_IMMEX: begin
                    bus.alusrca    = 1'b1;
                    bus.alusrcb    = 2'b10;
                    bus.alucontrol = (bus.op == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_IMMWB: begin
                    bus.regwrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_JUMP: begin
                    bus.pcsrc      = 2'b10;
                    bus.pcen       = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: bus.mem_req = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each cycle's expected state/outputs are queued
// with the stimulus, then popped and compared against the DUT on the falling edge.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dbg_state;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic [3:0]  st;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic        z;
        logic [21:0] exp;
    } item_t;

    item_t sb[$];

    multicycle_controller_if #(.ALU_W(3)) bus();

    multicycle_controller #(.STATE_W(4), .ALU_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference outputs per state, written directly from the state/output table.
    function automatic logic [21:0] exp_out(input logic [3:0] st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z, input logic mr);
        logic mreq, iord, mw, irw, rd, m2r, rw, asa, pe, done, ill;
        logic [1:0] asb, ps;
        logic [2:0] alu;
        {mreq, iord, mw, irw, rd, m2r, rw, asa, pe, done, ill} = 11'b0;
        asb = 2'b00; ps = 2'b00; alu = 3'b000;
        case (st)
            4'd0:  begin mreq = 1'b1; asb = 2'b01; alu = 3'b010; irw = mr; pe = mr; end
            4'd1:  begin
                asb = 2'b11; alu = 3'b010;
                ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 || op == 6'b000100 ||
                        op == 6'b001000 || op == 6'b001010 || op == 6'b000010);
            end
            4'd2:  begin asa = 1'b1; asb = 2'b10; alu = 3'b010; end
            4'd3:  begin mreq = 1'b1; iord = 1'b1; end
            4'd4:  begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
            4'd5:  begin mreq = 1'b1; iord = 1'b1; mw = mr; done = mr; end
            4'd6:  begin
                asa = 1'b1;
                if (fn == 6'b100010)      alu = 3'b110;
                else if (fn == 6'b100100) alu = 3'b000;
                else if (fn == 6'b100101) alu = 3'b001;
                else if (fn == 6'b101010) alu = 3'b111;
                else                      alu = 3'b010;
            end
            4'd7:  begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
            4'd8:  begin asa = 1'b1; alu = 3'b110; ps = 2'b01; pe = z; done = 1'b1; end
            4'd9:  begin asa = 1'b1; asb = 2'b10; alu = (op == 6'b001010) ? 3'b111 : 3'b010; end
            4'd10: begin rw = 1'b1; done = 1'b1; end
            4'd11: begin ps = 2'b10; pe = 1'b1; done = 1'b1; end
            default: alu = 3'b000;
        endcase
        return {st, mreq, iord, mw, irw, rd, m2r, rw, asa, asb, ps, pe, alu, done, ill};
    endfunction

    function automatic logic [21:0] act_vec();
        return {dbg_state, bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.regdst,
                bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
                bus.alucontrol, bus.instr_done, bus.illegal_op};
    endfunction

    task automatic push(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                        input logic mr, input logic z);
        item_t it;
        it.st = st; it.op = op; it.fn = fn; it.mr = mr; it.z = z;
        it.exp = exp_out(st, op, fn, z, mr);
        sb.push_back(it);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b1; bus.zero = 1'b1; bus.op = 6'b100011; bus.funct = 6'b100000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (act_vec() !== 22'd0) begin
                bad++; $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", i, act_vec(), 22'd0);
            end
        end
        bus.mem_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        total++;
        if (dbg_state !== 4'd0 || bus.mem_req !== 1'b1) begin
            bad++; $display("FAIL reset_release got state=%0d mem_req=%b exp state=0 mem_req=1",
                            dbg_state, bus.mem_req);
        end
    endtask

    task automatic test_lw();
        int dones = 0;
        item_t it;
        push(4'd0, 6'b100011, 6'd0, 1'b1, 1'b0);
        push(4'd1, 6'b100011, 6'd0, 1'b1, 1'b0);
        push(4'd2, 6'b100011, 6'd0, 1'b1, 1'b0);
        push(4'd3, 6'b100011, 6'd0, 1'b1, 1'b0);
        push(4'd4, 6'b100011, 6'd0, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk); bus.op = it.op; bus.funct = it.fn; bus.mem_ready = it.mr; bus.zero = it.z; #1;
            total++;
            if (act_vec() !== it.exp) begin
                bad++; $display("FAIL lw st=%0d got=%h exp=%h", it.st, act_vec(), it.exp);
            end
            dones += int'(bus.instr_done);
        end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL lw_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_sw_stall();
        int writes = 0;
        int cycles = 0;
        item_t it;
        push(4'd0, 6'b101011, 6'd0, 1'b1, 1'b0);
        push(4'd1, 6'b101011, 6'd0, 1'b0, 1'b0);
        push(4'd2, 6'b101011, 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(4'd5, 6'b101011, 6'd0, 1'b0, 1'b0);
        push(4'd5, 6'b101011, 6'd0, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk); bus.op = it.op; bus.funct = it.fn; bus.mem_ready = it.mr; bus.zero = it.z; #1;
            total++;
            if (act_vec() !== it.exp) begin
                bad++; $display("FAIL sw st=%0d got=%h exp=%h", it.st, act_vec(), it.exp);
            end
            writes += int'(bus.memwrite);
            cycles++;
        end
        total++;
        if (writes !== 1 || cycles !== 7) begin
            bad++; $display("FAIL sw_counts got writes=%0d cycles=%0d exp writes=1 cycles=7", writes, cycles);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] alus [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        item_t it;
        for (int k = 0; k < 5; k++) begin
            push(4'd0, 6'b000000, fns[k], 1'b1, 1'b0);
            push(4'd1, 6'b000000, fns[k], 1'b1, 1'b0);
            push(4'd6, 6'b000000, fns[k], 1'b1, 1'b0);
            push(4'd7, 6'b000000, fns[k], 1'b1, 1'b0);
            while (sb.size() != 0) begin
                it = sb.pop_front();
                @(negedge clk); bus.op = it.op; bus.funct = it.fn; bus.mem_ready = it.mr; bus.zero = it.z; #1;
                total++;
                if (act_vec() !== it.exp) begin
                    bad++; $display("FAIL rtype fn=%b st=%0d got=%h exp=%h", it.fn, it.st, act_vec(), it.exp);
                end
                if (it.st == 4'd6) begin
                    total++;
                    if (bus.alucontrol !== alus[k]) begin
                        bad++; $display("FAIL rtype_alu fn=%b got=%b exp=%b", it.fn, bus.alucontrol, alus[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_beq();
        item_t it;
        for (int z = 1; z >= 0; z--) begin
            push(4'd0, 6'b000100, 6'd0, 1'b1, 1'(z));
            push(4'd1, 6'b000100, 6'd0, 1'b1, 1'(z));
            push(4'd8, 6'b000100, 6'd0, 1'b1, 1'(z));
            while (sb.size() != 0) begin
                it = sb.pop_front();
                @(negedge clk); bus.op = it.op; bus.funct = it.fn; bus.mem_ready = it.mr; bus.zero = it.z; #1;
                total++;
                if (act_vec() !== it.exp) begin
                    bad++; $display("FAIL beq z=%b st=%0d got=%h exp=%h", it.z, it.st, act_vec(), it.exp);
                end
                if (it.st == 4'd8) begin
                    total++;
                    if (bus.pcen !== 1'(z) || bus.pcsrc !== 2'b01) begin
                        bad++; $display("FAIL beq_pc z=%0d got pcen=%b pcsrc=%b exp pcen=%0d pcsrc=01",
                                        z, bus.pcen, bus.pcsrc, z);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        item_t it;
        push(4'd0, 6'b000010, 6'd0, 1'b1, 1'b0);
        push(4'd1, 6'b000010, 6'd0, 1'b1, 1'b0);
        push(4'd11, 6'b000010, 6'd0, 1'b1, 1'b0);
        push(4'd0, 6'b001000, 6'd0, 1'b0, 1'b0);
        push(4'd0, 6'b001000, 6'd0, 1'b1, 1'b0);
        push(4'd1, 6'b001000, 6'd0, 1'b1, 1'b0);
        push(4'd9, 6'b001000, 6'd0, 1'b1, 1'b0);
        push(4'd10, 6'b001000, 6'd0, 1'b1, 1'b0);
        push(4'd0, 6'b001010, 6'd0, 1'b1, 1'b0);
        push(4'd1, 6'b001010, 6'd0, 1'b1, 1'b0);
        push(4'd9, 6'b001010, 6'd0, 1'b1, 1'b0);
        push(4'd10, 6'b001010, 6'd0, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk); bus.op = it.op; bus.funct = it.fn; bus.mem_ready = it.mr; bus.zero = it.z; #1;
            total++;
            if (act_vec() !== it.exp) begin
                bad++; $display("FAIL b2b op=%b st=%0d got=%h exp=%h", it.op, it.st, act_vec(), it.exp);
            end
        end
    endtask

    task automatic test_illegal_and_abort();
        item_t it;
        push(4'd0, 6'b111111, 6'd0, 1'b1, 1'b0);
        push(4'd1, 6'b111111, 6'd0, 1'b1, 1'b0);
        push(4'd0, 6'b100011, 6'd0, 1'b1, 1'b0);
        push(4'd1, 6'b100011, 6'd0, 1'b1, 1'b0);
        push(4'd2, 6'b100011, 6'd0, 1'b1, 1'b0);
        push(4'd3, 6'b100011, 6'd0, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk); bus.op = it.op; bus.funct = it.fn; bus.mem_ready = it.mr; bus.zero = it.z; #1;
            total++;
            if (act_vec() !== it.exp) begin
                bad++; $display("FAIL illegal_abort st=%0d got=%h exp=%h", it.st, act_vec(), it.exp);
            end
        end
        // Abort the load while it waits in MEMRD, with memory now claiming completion.
        #1; rst_n = 1'b0; bus.mem_ready = 1'b1; #1;
        total++;
        if (act_vec() !== 22'd0) begin
            bad++; $display("FAIL abort_in_reset got=%h exp=%h", act_vec(), 22'd0);
        end
        @(negedge clk); bus.mem_ready = 1'b0; rst_n = 1'b1; #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (act_vec() !== exp_out(4'd0, 6'b100011, 6'd0, 1'b0, 1'b0)) begin
                bad++; $display("FAIL abort_restart cyc=%0d got=%h exp=%h", i, act_vec(),
                                exp_out(4'd0, 6'b100011, 6'd0, 1'b0, 1'b0));
            end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype();
        test_beq();
        test_back_to_back();
        test_illegal_and_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
